// File: rtl/decode_hazard_ctrl.sv
// rtl/decode_hazard_ctrl.sv - decode-stage hazard scoreboard, flush and halt sequencing
//
// Optional feature macro: DECODE_HAZARD_FWD_EN (EX-stage load-use tracking replaces
// full scoreboard stalling on sources; WAW saturation guard kept).
//
// Ports:
//   clk, rst (async, active-low)
//   id_*       decode-stage instruction fields (valid, sources, destination, load, redirect, halt)
//   wb_en/sel  write-back return path, retires one in-flight write
//   mem_stall  freezes the pipeline
//   pc_en, ifid_en, ifid_flush, idex_bubble  pipeline latch controls
//   halted     pipeline frozen after HALT
//   stall_cnt  saturating count of hazard stall cycles
module decode_hazard_ctrl #(
  parameter int NUM_REGS = 8,
  parameter int CNT_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [2:0]  id_rs_sel,
  input  logic        id_rs_used,
  input  logic [2:0]  id_rt_sel,
  input  logic        id_rt_used,
  input  logic        id_wr_en,
  input  logic [2:0]  id_wr_sel,
  input  logic        id_is_load,
  input  logic        id_redirect,
  input  logic        id_halt,
  input  logic        wb_en,
  input  logic [2:0]  wb_sel,
  input  logic        mem_stall,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt      [NUM_REGS];
  logic [CNT_W-1:0] cnt_next [NUM_REGS];
  logic             all_zero_next;
  logic             src_rs;
  logic             src_rt;
  logic             hazard;
  logic             issue;

`ifdef DECODE_HAZARD_FWD_EN
  logic       ex_valid;
  logic       ex_is_load;
  logic [2:0] ex_wr_sel;

  // Only a load still in EX cannot be forwarded in time.
  always_comb begin
    src_rs = ex_valid & ex_is_load & (ex_wr_sel == id_rs_sel);
    src_rt = ex_valid & ex_is_load & (ex_wr_sel == id_rt_sel);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid   <= 1'b0;
      ex_is_load <= 1'b0;
      ex_wr_sel  <= 3'd0;
    end else if (!mem_stall) begin
      ex_valid <= issue;
      if (issue) begin
        ex_is_load <= id_is_load & id_wr_en;
        ex_wr_sel  <= id_wr_sel;
      end
    end
  end
`else
  logic unused_is_load;
  assign unused_is_load = id_is_load;

  // A last outstanding write retiring this cycle is covered by the register-file bypass.
  always_comb begin
    src_rs = (cnt[id_rs_sel] != '0) &
             ~((cnt[id_rs_sel] == CNT_W'(1)) & wb_en & (wb_sel == id_rs_sel));
    src_rt = (cnt[id_rt_sel] != '0) &
             ~((cnt[id_rt_sel] == CNT_W'(1)) & wb_en & (wb_sel == id_rt_sel));
  end
`endif

  // Last term keeps a per-register counter from wrapping on repeated writes.
  assign hazard = (id_rs_used & src_rs) | (id_rt_used & src_rt) |
                  (id_wr_en & (cnt[id_wr_sel] == CNT_MAX));
  assign issue  = id_valid & ~hazard & ~mem_stall & (state == RUN);
  assign halted = (state == HALTED);

  always_comb begin
    all_zero_next = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      logic inc_r;
      logic dec_r;
      inc_r = issue & id_wr_en & (id_wr_sel == 3'(r));
      dec_r = wb_en & (wb_sel == 3'(r));
      cnt_next[r] = cnt[r];
      if (inc_r && !dec_r) begin
        cnt_next[r] = cnt[r] + CNT_W'(1);
      end else if (dec_r && !inc_r && (cnt[r] != '0)) begin
        cnt_next[r] = cnt[r] - CNT_W'(1);
      end
      if (cnt_next[r] != '0) begin
        all_zero_next = 1'b0;
      end
    end
  end

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b1;
    if (mem_stall) begin
      // ID/EX holds its contents rather than taking a bubble.
      idex_bubble = 1'b0;
    end else begin
      case (state)
        RUN: begin
          pc_en       = ~hazard;
          ifid_en     = ~hazard;
          idex_bubble = hazard | ~id_valid;
        end
        FLUSH: begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      stall_cnt <= 16'd0;
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt[r] <= cnt_next[r];
      end
      if ((state == RUN) && hazard && !mem_stall && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if (!mem_stall) begin
        case (state)
          RUN: begin
            if (issue && id_halt) begin
              state <= DRAIN;
            end else if (issue && id_redirect) begin
              state <= FLUSH;
            end
          end
          FLUSH:   state <= RUN;
          // Uses post-update counters so the final write-back ends the drain.
          DRAIN:   if (all_zero_next) state <= HALTED;
          default: state <= HALTED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb/tb_decode_hazard_ctrl.sv - directed self-checking bench for decode_hazard_ctrl
module tb_decode_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [2:0]  id_rs_sel;
  logic        id_rs_used;
  logic [2:0]  id_rt_sel;
  logic        id_rt_used;
  logic        id_wr_en;
  logic [2:0]  id_wr_sel;
  logic        id_is_load;
  logic        id_redirect;
  logic        id_halt;
  logic        wb_en;
  logic [2:0]  wb_sel;
  logic        mem_stall;
  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        halted;
  logic [15:0] stall_cnt;

  int n_assert;
  int n_fail;

  decode_hazard_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs_sel   (id_rs_sel),
    .id_rs_used  (id_rs_used),
    .id_rt_sel   (id_rt_sel),
    .id_rt_used  (id_rt_used),
    .id_wr_en    (id_wr_en),
    .id_wr_sel   (id_wr_sel),
    .id_is_load  (id_is_load),
    .id_redirect (id_redirect),
    .id_halt     (id_halt),
    .wb_en       (wb_en),
    .wb_sel      (wb_sel),
    .mem_stall   (mem_stall),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_bubble (idex_bubble),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic dec(input logic v, input logic [2:0] rs, input logic ru,
                     input logic [2:0] rt, input logic tu,
                     input logic we, input logic [2:0] wd);
    id_valid    = v;
    id_rs_sel   = rs;
    id_rs_used  = ru;
    id_rt_sel   = rt;
    id_rt_used  = tu;
    id_wr_en    = we;
    id_wr_sel   = wd;
    id_is_load  = 1'b0;
    id_redirect = 1'b0;
    id_halt     = 1'b0;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    dec(0, 0, 0, 0, 0, 0, 0);
    wb_en     = 1'b0;
    wb_sel    = 3'd0;
    mem_stall = 1'b0;

    tick(); #1;
    chk("rst_pc_en", pc_en, 1);
    chk("rst_ifid_en", ifid_en, 1);
    chk("rst_flush", ifid_flush, 0);
    chk("rst_bubble", idex_bubble, 1);
    chk("rst_halted", halted, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    tick(); rst = 1'b1;

`ifndef DECODE_HAZARD_FWD_EN
    // ADD r1 then SUB r2,r1: two stall cycles, issue on write-back of r1
    tick(); dec(1, 2, 1, 3, 1, 1, 1); #1;
    chk("add_pc_en", pc_en, 1);
    chk("add_bubble", idex_bubble, 0);
    tick(); dec(1, 1, 1, 3, 1, 1, 2); #1;
    chk("raw1_pc_en", pc_en, 0);
    chk("raw1_ifid_en", ifid_en, 0);
    chk("raw1_bubble", idex_bubble, 1);
    tick(); #1;
    chk("raw2_pc_en", pc_en, 0);
    chk("raw2_stall_cnt", stall_cnt, 1);
    tick(); wb_en = 1'b1; wb_sel = 3'd1; #1;
    chk("raw_bypass_pc_en", pc_en, 1);
    chk("raw_bypass_bubble", idex_bubble, 0);
    chk("raw_stall_cnt", stall_cnt, 2);
    tick(); dec(0, 0, 0, 0, 0, 0, 0); wb_sel = 3'd2; #1;
    chk("idle_bubble", idex_bubble, 1);
    chk("idle_pc_en", pc_en, 1);

    // taken branch: exactly one flush cycle
    tick(); wb_en = 1'b0; dec(1, 0, 0, 0, 0, 0, 0); id_redirect = 1'b1; #1;
    chk("br_issue_flush", ifid_flush, 0);
    chk("br_issue_pc_en", pc_en, 1);
    tick(); dec(0, 0, 0, 0, 0, 0, 0); #1;
    chk("flush_flush", ifid_flush, 1);
    chk("flush_pc_en", pc_en, 1);
    chk("flush_ifid_en", ifid_en, 1);
    chk("flush_bubble", idex_bubble, 1);
    tick(); #1;
    chk("post_flush", ifid_flush, 0);
    chk("post_flush_pc_en", pc_en, 1);

    // redirect blocked by a hazard waits for the branch to issue
    tick(); dec(1, 0, 0, 0, 0, 1, 6);
    tick(); dec(1, 6, 1, 0, 0, 0, 0); id_redirect = 1'b1; #1;
    chk("brhz_pc_en", pc_en, 0);
    chk("brhz_flush", ifid_flush, 0);
    tick(); #1;
    chk("brhz2_flush", ifid_flush, 0);
    chk("brhz2_stall_cnt", stall_cnt, 3);
    tick(); wb_en = 1'b1; wb_sel = 3'd6; #1;
    chk("brhz_issue_pc_en", pc_en, 1);
    chk("brhz_issue_stall_cnt", stall_cnt, 4);
    tick(); dec(0, 0, 0, 0, 0, 0, 0); wb_en = 1'b0; #1;
    chk("brhz_flush_now", ifid_flush, 1);
    tick(); #1;
    chk("brhz_flush_done", ifid_flush, 0);

    // mem_stall over a pending hazard; write-backs still retire
    tick(); dec(1, 0, 0, 0, 0, 1, 1);
    tick(); dec(1, 0, 0, 0, 0, 1, 7);
    tick(); dec(1, 1, 1, 7, 1, 0, 0); mem_stall = 1'b1; wb_en = 1'b1; wb_sel = 3'd7; #1;
    chk("ms1_pc_en", pc_en, 0);
    chk("ms1_ifid_en", ifid_en, 0);
    chk("ms1_bubble", idex_bubble, 0);
    chk("ms1_stall_cnt", stall_cnt, 4);
    tick(); wb_sel = 3'd1; #1;
    chk("ms2_pc_en", pc_en, 0);
    chk("ms2_stall_cnt", stall_cnt, 4);
    tick(); wb_en = 1'b0; #1;
    chk("ms3_bubble", idex_bubble, 0);
    chk("ms3_stall_cnt", stall_cnt, 4);
    tick(); mem_stall = 1'b0; #1;
    chk("ms_release_pc_en", pc_en, 1);
    chk("ms_release_bubble", idex_bubble, 0);
    chk("ms_release_stall_cnt", stall_cnt, 4);

    // WAW saturation: at most three writes to r4 in flight
    tick(); dec(1, 0, 0, 0, 0, 1, 4);
    tick();
    tick(); #1;
    chk("waw3_pc_en", pc_en, 1);
    tick(); #1;
    chk("waw4_pc_en", pc_en, 0);
    chk("waw4_stall_cnt", stall_cnt, 4);
    tick(); wb_en = 1'b1; wb_sel = 3'd4; #1;
    chk("waw_wb_pc_en", pc_en, 0);
    chk("waw_wb_stall_cnt", stall_cnt, 5);
    tick(); wb_en = 1'b0; #1;
    chk("waw_free_pc_en", pc_en, 1);
    chk("waw_free_stall_cnt", stall_cnt, 6);
    tick(); dec(0, 0, 0, 0, 0, 0, 0); wb_en = 1'b1; wb_sel = 3'd4;
    tick();
    tick();

    // HALT with an r3 write outstanding
    tick(); wb_en = 1'b0; dec(1, 0, 0, 0, 0, 1, 3); #1;
    chk("r3_issue_pc_en", pc_en, 1);
    tick(); dec(1, 0, 0, 0, 0, 0, 0); id_halt = 1'b1; #1;
    chk("halt_issue_pc_en", pc_en, 1);
    chk("halt_issue_bubble", idex_bubble, 0);
    tick(); dec(0, 0, 0, 0, 0, 0, 0); #1;
    chk("drain_pc_en", pc_en, 0);
    chk("drain_ifid_en", ifid_en, 0);
    chk("drain_bubble", idex_bubble, 1);
    chk("drain_halted", halted, 0);
    tick(); wb_en = 1'b1; wb_sel = 3'd3; #1;
    chk("drain_wb_pc_en", pc_en, 0);
    chk("drain_wb_halted", halted, 0);
    tick(); wb_en = 1'b0; #1;
    chk("halted_halted", halted, 1);
    chk("halted_pc_en", pc_en, 0);
    chk("halted_bubble", idex_bubble, 1);
    tick(); dec(1, 0, 0, 0, 0, 0, 0); #1;
    chk("halted_stays", halted, 1);
    chk("halted_ifid_en", ifid_en, 0);

    // asynchronous reset out of HALTED
    tick(); dec(0, 0, 0, 0, 0, 0, 0); #1; rst = 1'b0; #1;
    chk("arst_halted", halted, 0);
    chk("arst_pc_en", pc_en, 1);
    chk("arst_stall_cnt", stall_cnt, 0);
    tick(); rst = 1'b1;

    // reset mid-DRAIN with two writes to r5 outstanding
    tick(); dec(1, 0, 0, 0, 0, 1, 5);
    tick();
    tick(); dec(1, 0, 0, 0, 0, 0, 0); id_halt = 1'b1;
    tick(); dec(0, 0, 0, 0, 0, 0, 0); #1;
    chk("r5_drain_pc_en", pc_en, 0);
    #1; rst = 1'b0; #1;
    chk("mid_rst_pc_en", pc_en, 1);
    chk("mid_rst_halted", halted, 0);
    chk("mid_rst_flush", ifid_flush, 0);
    tick(); rst = 1'b1; dec(1, 5, 1, 5, 1, 1, 5); #1;
    chk("r5_cleared_pc_en", pc_en, 1);
    chk("r5_cleared_bubble", idex_bubble, 0);
`else
    // load-use: one stall cycle
    tick(); dec(1, 0, 0, 0, 0, 1, 4); id_is_load = 1'b1; #1;
    chk("ld_pc_en", pc_en, 1);
    tick(); dec(1, 4, 1, 0, 0, 1, 5); #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_bubble", idex_bubble, 1);
    chk("lu_stall_cnt", stall_cnt, 0);
    tick(); #1;
    chk("lu_issue_pc_en", pc_en, 1);
    chk("lu_issue_bubble", idex_bubble, 0);
    chk("lu_stall_cnt1", stall_cnt, 1);
    // ALU producer forwards: no stall
    tick(); dec(1, 0, 0, 0, 0, 1, 4); #1;
    chk("alu_pc_en", pc_en, 1);
    tick(); dec(1, 4, 1, 0, 0, 1, 5); #1;
    chk("fwd_pc_en", pc_en, 1);
    tick(); dec(0, 0, 0, 0, 0, 0, 0); #1;
    chk("fwd_stall_cnt", stall_cnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
